// File: rtl/fp_flag_window_checker_if.sv
// Bus between an FP datapath under test and fp_flag_window_checker: result, flags and check results.
interface fp_flag_window_checker_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned CNT_W = 16
);
   logic [EXP_W+MAN_W:0] fp_z;
   logic                 ovrf;
   logic                 udrf;
   logic                 ovr_pass;
   logic                 ovr_err;
   logic                 und_pass;
   logic                 und_err;
   logic [CNT_W-1:0]     ovr_pass_cnt;
   logic [CNT_W-1:0]     ovr_err_cnt;
   logic [CNT_W-1:0]     und_pass_cnt;
   logic [CNT_W-1:0]     und_err_cnt;

   modport master (
      output fp_z, ovrf, udrf,
      input  ovr_pass, ovr_err, und_pass, und_err,
      input  ovr_pass_cnt, ovr_err_cnt, und_pass_cnt, und_err_cnt
   );

   modport slave (
      input  fp_z, ovrf, udrf,
      output ovr_pass, ovr_err, und_pass, und_err,
      output ovr_pass_cnt, ovr_err_cnt, und_pass_cnt, und_err_cnt
   );
endinterface

// File: rtl/fp_flag_window_checker.sv
// Checks that ovrf/udrf rise within MAX_LAT cycles of the result exponent saturating.
// Optional FP_CHK_INF_ONLY_EN: only an Inf result (zero mantissa) arms the overflow check.
module fp_flag_window_checker #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned MAX_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
   input logic                      clk,
   input logic                      rst,
   fp_flag_window_checker_if.slave  bus
);

   localparam int unsigned LatW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [LatW-1:0] LatLast = LatW'((MAX_LAT > 0) ? MAX_LAT - 1 : 0);
   localparam bit HasWin = (MAX_LAT > 0);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   logic [EXP_W-1:0] exp_w;
   logic [MAN_W-1:0] man_w;
   logic             ovr_cond, und_cond;
   logic             ovr_cond_q, und_cond_q, ovrf_q, udrf_q;
   logic [1:0]       trig, rise;

   assign exp_w = bus.fp_z[MAN_W +: EXP_W];
   assign man_w = bus.fp_z[MAN_W-1:0];

`ifdef FP_CHK_INF_ONLY_EN
   assign ovr_cond = (&exp_w) && (man_w == '0);
   logic unused_sign;
   assign unused_sign = bus.fp_z[EXP_W+MAN_W];
`else
   assign ovr_cond = &exp_w;
   logic unused_bits;
   assign unused_bits = ^{bus.fp_z[EXP_W+MAN_W], man_w};
`endif
   assign und_cond = ~|exp_w;

   // History regs reset high so a level already present at release is not taken as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_cond_q <= 1'b1;
         und_cond_q <= 1'b1;
         ovrf_q     <= 1'b1;
         udrf_q     <= 1'b1;
      end else begin
         ovr_cond_q <= ovr_cond;
         und_cond_q <= und_cond;
         ovrf_q     <= bus.ovrf;
         udrf_q     <= bus.udrf;
      end
   end

   assign trig = {und_cond & ~und_cond_q, ovr_cond & ~ovr_cond_q};
   assign rise = {bus.udrf & ~udrf_q, bus.ovrf & ~ovrf_q};

   // Index 0 is the overflow path, index 1 the underflow path.
   for (genvar g = 0; g < 2; g++) begin : g_path
      state_e           state_q, state_d;
      logic [LatW-1:0]  lat_q, lat_d;
      logic             pass_d, err_d, pass_q, err_q;
      logic [CNT_W-1:0] pass_cnt_q, err_cnt_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= StIdle;
            lat_q   <= '0;
         end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
         end
      end

      always_comb begin
         state_d = state_q;
         lat_d   = lat_q;
         unique case (state_q)
            StIdle: begin
               if (trig[g] && !rise[g] && HasWin) begin
                  state_d = StWait;
                  lat_d   = '0;
               end
            end
            StWait: begin
               if (trig[g]) begin
                  lat_d = '0;
               end else if (rise[g] || (lat_q == LatLast)) begin
                  state_d = StIdle;
               end else begin
                  lat_d = lat_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // A re-trigger in WAIT resolves the pending window on the same edge it reopens.
      always_comb begin
         pass_d = 1'b0;
         err_d  = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (trig[g]) begin
                  pass_d = rise[g];
                  err_d  = !rise[g] && !HasWin;
               end
            end
            StWait: begin
               pass_d = rise[g];
               err_d  = !rise[g] && (trig[g] || (lat_q == LatLast));
            end
            default: ;
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pass_q     <= 1'b0;
            err_q      <= 1'b0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
         end else begin
            pass_q <= pass_d;
            err_q  <= err_d;
            if (pass_q && (pass_cnt_q != '1)) pass_cnt_q <= pass_cnt_q + 1'b1;
            if (err_q && (err_cnt_q != '1))   err_cnt_q  <= err_cnt_q + 1'b1;
         end
      end
   end

   assign bus.ovr_pass     = g_path[0].pass_q;
   assign bus.ovr_err      = g_path[0].err_q;
   assign bus.und_pass     = g_path[1].pass_q;
   assign bus.und_err      = g_path[1].err_q;
   assign bus.ovr_pass_cnt = g_path[0].pass_cnt_q;
   assign bus.ovr_err_cnt  = g_path[0].err_cnt_q;
   assign bus.und_pass_cnt = g_path[1].pass_cnt_q;
   assign bus.und_err_cnt  = g_path[1].err_cnt_q;

endmodule

// File: tb/tb_fp_flag_window_checker.sv
// Directed bench for fp_flag_window_checker with MAX_LAT of 1, 0 and 3 and a 2-bit counter build.
module tb_fp_flag_window_checker;

   localparam logic [31:0] FpOne  = 32'h3F80_0000;
   localparam logic [31:0] FpInf  = 32'h7F80_0000;
   localparam logic [31:0] FpNan  = 32'h7FC0_0000;
   localparam logic [31:0] FpZero = 32'h0000_0000;
   localparam logic [31:0] FpTwo  = 32'h4000_0000;

   logic        clk, rst;
   logic [31:0] fp_z;
   logic        ovrf, udrf;
   int          tests, fails;

   fp_flag_window_checker_if #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) if_main ();
   fp_flag_window_checker_if #(.EXP_W(8), .MAN_W(23), .CNT_W(2))  if_sat ();
   fp_flag_window_checker_if #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) if_l0 ();
   fp_flag_window_checker_if #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) if_l3 ();

   assign if_main.fp_z = fp_z; assign if_main.ovrf = ovrf; assign if_main.udrf = udrf;
   assign if_sat.fp_z  = fp_z; assign if_sat.ovrf  = ovrf; assign if_sat.udrf  = udrf;
   assign if_l0.fp_z   = fp_z; assign if_l0.ovrf   = ovrf; assign if_l0.udrf   = udrf;
   assign if_l3.fp_z   = fp_z; assign if_l3.ovrf   = ovrf; assign if_l3.udrf   = udrf;

   fp_flag_window_checker #(.EXP_W(8), .MAN_W(23), .MAX_LAT(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .bus(if_main));
   fp_flag_window_checker #(.EXP_W(8), .MAN_W(23), .MAX_LAT(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .bus(if_sat));
   fp_flag_window_checker #(.EXP_W(8), .MAN_W(23), .MAX_LAT(0), .CNT_W(16)) u_l0 (
      .clk(clk), .rst(rst), .bus(if_l0));
   fp_flag_window_checker #(.EXP_W(8), .MAN_W(23), .MAX_LAT(3), .CNT_W(16)) u_l3 (
      .clk(clk), .rst(rst), .bus(if_l3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled and inputs changed 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fp_z = FpOne; ovrf = 1'b0; udrf = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; fp_z = FpInf; ovrf = 1'b1; udrf = 1'b1;
      tick();
      tests++;
      if ({if_main.ovr_pass, if_main.ovr_err, if_main.und_pass, if_main.und_err} !== 4'b0) begin
         fails++;
         $display("FAIL reset_pulses: got %b want 0000", {if_main.ovr_pass, if_main.ovr_err,
                  if_main.und_pass, if_main.und_err});
      end
      tests++;
      if ({if_main.ovr_pass_cnt, if_main.ovr_err_cnt, if_main.und_pass_cnt,
           if_main.und_err_cnt} !== 64'h0) begin
         fails++;
         $display("FAIL reset_counters: got %h want 0", {if_main.ovr_pass_cnt,
                  if_main.ovr_err_cnt, if_main.und_pass_cnt, if_main.und_err_cnt});
      end
      // Inputs already high at release must not look like edges.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if ({if_main.ovr_pass, if_main.ovr_err, if_l0.ovr_err, if_l0.ovr_pass} !== 4'b0) begin
            fails++;
            $display("FAIL reset_no_edge cycle %0d: got %b want 0000", i, {if_main.ovr_pass,
                     if_main.ovr_err, if_l0.ovr_err, if_l0.ovr_pass});
         end
      end
   endtask

   task automatic test_ovr_pass();
      do_reset();
      fp_z = FpInf;              // cycle T
      tick();                    // T+1
      tests++;
      if (if_l0.ovr_err !== 1'b1) begin
         fails++; $display("FAIL ovr_lat0_err: got %b want 1", if_l0.ovr_err);
      end
      tests++;
      if (if_main.ovr_pass !== 1'b0) begin
         fails++; $display("FAIL ovr_pass_early: got %b want 0", if_main.ovr_pass);
      end
      ovrf = 1'b1;
      tick();                    // T+2
      tests++;
      if ({if_main.ovr_pass, if_main.ovr_err, if_l3.ovr_pass} !== 3'b101) begin
         fails++; $display("FAIL ovr_pass_pulse: got %b want 101", {if_main.ovr_pass,
                           if_main.ovr_err, if_l3.ovr_pass});
      end
      tick();                    // T+3
      tests++;
      if (if_main.ovr_pass_cnt !== 16'd1 || if_main.ovr_err_cnt !== 16'd0) begin
         fails++; $display("FAIL ovr_pass_cnt: got %0d/%0d want 1/0", if_main.ovr_pass_cnt,
                           if_main.ovr_err_cnt);
      end
      tests++;
      if (if_l0.ovr_err_cnt !== 16'd1 || if_l0.ovr_pass_cnt !== 16'd0) begin
         fails++; $display("FAIL ovr_lat0_cnt: got %0d/%0d want 1/0", if_l0.ovr_err_cnt,
                           if_l0.ovr_pass_cnt);
      end
   endtask

   task automatic test_und_err();
      do_reset();
      fp_z = FpZero;             // cycle T
      tick();                    // T+1
      tests++;
      if ({if_main.und_err, if_l0.und_err} !== 2'b01) begin
         fails++; $display("FAIL und_t1: got %b want 01", {if_main.und_err, if_l0.und_err});
      end
      tick();                    // T+2
      tests++;
      if ({if_main.und_err, if_main.und_pass, if_l3.und_err} !== 3'b100) begin
         fails++; $display("FAIL und_err_pulse: got %b want 100", {if_main.und_err,
                           if_main.und_pass, if_l3.und_err});
      end
      tick();                    // T+3
      tests++;
      if (if_main.und_err_cnt !== 16'd1 || if_main.und_pass_cnt !== 16'd0 ||
          if_main.ovr_err_cnt !== 16'd0) begin
         fails++; $display("FAIL und_err_cnt: got %0d/%0d/%0d want 1/0/0", if_main.und_err_cnt,
                           if_main.und_pass_cnt, if_main.ovr_err_cnt);
      end
      tests++;
      if (if_l3.und_err !== 1'b0) begin
         fails++; $display("FAIL und_lat3_early: got %b want 0", if_l3.und_err);
      end
      tick();                    // T+4
      tests++;
      if (if_l3.und_err !== 1'b1) begin
         fails++; $display("FAIL und_lat3_err: got %b want 1", if_l3.und_err);
      end
   endtask

   task automatic test_nan();
      logic exp_err;
`ifdef FP_CHK_INF_ONLY_EN
      exp_err = 1'b0;
`else
      exp_err = 1'b1;
`endif
      do_reset();
      fp_z = FpNan;              // cycle T
      tick(); tick();            // T+2
      tests++;
      if (if_main.ovr_err !== exp_err || if_main.ovr_pass !== 1'b0) begin
         fails++; $display("FAIL nan_pulse: got err=%b pass=%b want err=%b pass=0",
                           if_main.ovr_err, if_main.ovr_pass, exp_err);
      end
      tick();
      tests++;
      if (if_main.ovr_err_cnt !== {15'd0, exp_err} || if_main.ovr_pass_cnt !== 16'd0) begin
         fails++; $display("FAIL nan_cnt: got %0d/%0d want %0d/0", if_main.ovr_err_cnt,
                           if_main.ovr_pass_cnt, exp_err);
      end
   endtask

   task automatic test_reset_mid_window();
      do_reset();
      fp_z = FpInf; ovrf = 1'b1;  // same-cycle pass leaves a nonzero counter
      tick(); tick();
      fp_z = FpOne; ovrf = 1'b0;
      tick();
      fp_z = FpZero;             // cycle T: underflow window opens
      tick();                    // T+1
      rst = 1'b1;
      #1;
      tests++;
      if (if_main.ovr_pass_cnt !== 16'd0 || if_main.und_err_cnt !== 16'd0) begin
         fails++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", if_main.ovr_pass_cnt,
                           if_main.und_err_cnt);
      end
      tick();                    // T+2
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tests++;
         if ({if_main.und_err, if_main.und_pass, if_main.und_err_cnt} !== 18'h0) begin
            fails++; $display("FAIL rst_mid_pulse cycle %0d: got %b/%b/%0d want 0/0/0", i,
                              if_main.und_err, if_main.und_pass, if_main.und_err_cnt);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         fp_z = FpInf; ovrf = 1'b1;
         tick();
         tests++;
         if (if_sat.ovr_pass !== 1'b1 || if_l0.ovr_pass !== 1'b1) begin
            fails++; $display("FAIL sat_pass_pulse %0d: got %b/%b want 1/1", i,
                              if_sat.ovr_pass, if_l0.ovr_pass);
         end
         fp_z = FpOne; ovrf = 1'b0;
         tick();
      end
      tick();
      tests++;
      if (if_sat.ovr_pass_cnt !== 2'd3 || if_sat.ovr_err_cnt !== 2'd0) begin
         fails++; $display("FAIL sat_cnt: got %0d/%0d want 3/0", if_sat.ovr_pass_cnt,
                           if_sat.ovr_err_cnt);
      end
      tests++;
      if (if_main.ovr_pass_cnt !== 16'd5 || if_l0.ovr_pass_cnt !== 16'd5) begin
         fails++; $display("FAIL wide_cnt: got %0d/%0d want 5/5", if_main.ovr_pass_cnt,
                           if_l0.ovr_pass_cnt);
      end
   endtask

   task automatic test_stray_flag();
      do_reset();
      fp_z = FpTwo;
      tick();
      udrf = 1'b1; ovrf = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if ({if_main.ovr_pass, if_main.ovr_err, if_main.und_pass, if_main.und_err,
              if_l3.und_pass, if_l0.und_pass} !== 6'b0) begin
            fails++; $display("FAIL stray_flag cycle %0d: got %b want 000000", i,
                              {if_main.ovr_pass, if_main.ovr_err, if_main.und_pass,
                               if_main.und_err, if_l3.und_pass, if_l0.und_pass});
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fp_z = FpInf;              // T: first window
      tick();                    // T+1
      fp_z = FpOne;
      tick();                    // T+2: re-trigger with no flag
      fp_z = FpInf;
      tick();                    // T+3
      tests++;
      if ({if_l3.ovr_err, if_l3.ovr_pass} !== 2'b10) begin
         fails++; $display("FAIL retrig_err: got %b want 10", {if_l3.ovr_err, if_l3.ovr_pass});
      end
      ovrf = 1'b1;
      tick();                    // T+4: flag rose at T+3, window opened at T+2
      tests++;
      if ({if_l3.ovr_err, if_l3.ovr_pass} !== 2'b01) begin
         fails++; $display("FAIL retrig_pass: got %b want 01", {if_l3.ovr_err, if_l3.ovr_pass});
      end
      tick(); tick();
      tests++;
      if (if_l3.ovr_err_cnt !== 16'd1 || if_l3.ovr_pass_cnt !== 16'd1) begin
         fails++; $display("FAIL retrig_cnt: got %0d/%0d want 1/1", if_l3.ovr_err_cnt,
                           if_l3.ovr_pass_cnt);
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; fp_z = FpOne; ovrf = 1'b0; udrf = 1'b0;
      test_reset();
      test_ovr_pass();
      test_und_err();
      test_nan();
      test_reset_mid_window();
      test_saturation();
      test_stray_flag();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
